dig_tx: RTL and testbench

DIG_TX -- requirements
Module: dig_tx

---
 rtl/dig_tx.sv | 163 ++++++++++++++++
 tb/tb_dig_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dig_tx.sv
// dig_tx: 3-bit serial transmitter. A frame is a start bit (0), DATA_IN[0..2]
// LSB first, an optional even-parity bit and a stop bit (1). Each bit lasts
// CLKS_PER_BIT clock cycles.
// Optional feature macro: DIG_TX_PARITY_EN (adds the even-parity bit).
// Reset is synchronous and active-low.
module dig_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] DATA_IN,
    input  logic       DATA_VLD,
    output logic       TX_OUT,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // The bit counter is a fixed 8 bits wide so every legal CLKS_PER_BIT fits.
    localparam logic [7:0] LAST_CNT    = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] PRELAST_CNT = 8'(CLKS_PER_BIT - 2);

    state_t     r_state;
    logic [7:0] r_bitCnt;
    logic [1:0] r_bitIdx;
    logic [2:0] r_shiftReg;
    logic       r_txOut;
    logic       r_busy;
    logic       r_done;

    logic       w_bitLast;
    logic       w_donePre;
    logic       w_dataLast;
    logic       w_nextBit;
`ifdef DIG_TX_PARITY_EN
    logic       w_parity;
`endif

    assign w_bitLast  = (r_bitCnt == LAST_CNT);
    assign w_donePre  = (r_bitCnt == PRELAST_CNT);
    assign w_dataLast = (r_bitIdx == 2'd2);
`ifdef DIG_TX_PARITY_EN
    assign w_parity   = ^r_shiftReg;
`endif

    // Pick the data bit that follows the one currently on the line.
    always_comb begin
        w_nextBit = r_shiftReg[0];
        case (r_bitIdx)
            2'd0:    w_nextBit = r_shiftReg[1];
            2'd1:    w_nextBit = r_shiftReg[2];
            default: w_nextBit = r_shiftReg[0];
        endcase
    end

    // Frame sequencer: state, bit timing and registered line outputs together.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_bitCnt   <= 8'd0;
            r_bitIdx   <= 2'd0;
            r_shiftReg <= 3'b000;
            r_txOut    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_bitCnt <= 8'd0;
                    r_bitIdx <= 2'd0;
                    if (DATA_VLD) begin
                        r_shiftReg <= DATA_IN;
                        r_state    <= START;
                        r_txOut    <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_txOut <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end

                START: begin
                    if (w_bitLast) begin
                        r_state  <= DATA;
                        r_bitCnt <= 8'd0;
                        r_bitIdx <= 2'd0;
                        r_txOut  <= r_shiftReg[0];
                    end else begin
                        r_bitCnt <= r_bitCnt + 8'd1;
                    end
                end

                DATA: begin
                    if (w_bitLast) begin
                        r_bitCnt <= 8'd0;
                        if (w_dataLast) begin
                            r_bitIdx <= 2'd0;
`ifdef DIG_TX_PARITY_EN
                            r_state  <= PARITY;
                            r_txOut  <= w_parity;
`else
                            r_state  <= STOP;
                            r_txOut  <= 1'b1;
`endif
                        end else begin
                            r_bitIdx <= r_bitIdx + 2'd1;
                            r_txOut  <= w_nextBit;
                        end
                    end else begin
                        r_bitCnt <= r_bitCnt + 8'd1;
                    end
                end

`ifdef DIG_TX_PARITY_EN
                PARITY: begin
                    if (w_bitLast) begin
                        r_state  <= STOP;
                        r_bitCnt <= 8'd0;
                        r_bitIdx <= 2'd0;
                        r_txOut  <= 1'b1;
                    end else begin
                        r_bitCnt <= r_bitCnt + 8'd1;
                    end
                end
`endif

                STOP: begin
                    if (w_bitLast) begin
                        r_state  <= IDLE;
                        r_bitCnt <= 8'd0;
                        r_bitIdx <= 2'd0;
                        r_txOut  <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_bitCnt <= r_bitCnt + 8'd1;
                        r_done   <= w_donePre;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_bitCnt <= 8'd0;
                    r_bitIdx <= 2'd0;
                    r_txOut  <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = r_txOut;
    assign BUSY   = r_busy;
    assign DONE   = r_done;

endmodule

// File: tb/tb_dig_tx.sv
// tb_dig_tx: testbench for dig_tx with CLKS_PER_BIT = 4.
// Builds with or without DIG_TX_PARITY_EN; the expected frames follow the macro.
module tb_dig_tx;

    localparam int C = 4;
`ifdef DIG_TX_PARITY_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif
    localparam int L = NB * C;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [2:0] DATA_IN = 3'b000;
    logic       DATA_VLD = 1'b0;
    logic       TX_OUT;
    logic       BUSY;
    logic       DONE;

    int checks = 0;
    int errors = 0;

    dig_tx #(.CLKS_PER_BIT(C)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .DATA_IN (DATA_IN),
        .DATA_VLD(DATA_VLD),
        .TX_OUT  (TX_OUT),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    // Free-running clock, 10 time units per period.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Reference model: a queue of expected {tx, busy, done} per upcoming cycle.
    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } obs_t;

    obs_t q[$];
    obs_t cur = 3'b100;

    function automatic void pushFrame(input logic [2:0] d);
        logic bits[$];
        bits = {1'b0, d[0], d[1], d[2]};
`ifdef DIG_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        for (int i = 0; i < bits.size(); i++) begin
            for (int j = 0; j < C; j++) begin
                q.push_back({bits[i], 1'b1, (i == bits.size() - 1) && (j == C - 1)});
            end
        end
    endfunction

    // Advance the model at each rising edge and compare the DUT shortly after.
    always begin
        @(posedge CLK);
        if (!RST) begin
            q.delete();
            cur = 3'b100;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (!cur.busy && DATA_VLD) begin
            pushFrame(DATA_IN);
            cur = q.pop_front();
        end else begin
            cur = 3'b100;
        end
        #1;
        checkOutput("model_tx", TX_OUT, cur.tx);
        checkOutput("model_busy", BUSY, cur.busy);
        checkOutput("model_done", DONE, cur.done);
    end

    // Table of code words and the bit sequence expected on the line, first bit at MSB of NB.
    typedef struct {
        logic [2:0] data;
        logic [5:0] bits;
    } vec_t;

    vec_t vecs[5];

    task automatic applyStimulus(input vec_t v, input int id, input bit holdVld);
        int busyCnt;
        int doneCnt;
        int doneAt;
        busyCnt = 0;
        doneCnt = 0;
        doneAt  = 0;
        DATA_IN  = v.data;
        DATA_VLD = 1'b1;
        for (int n = 1; n <= L; n++) begin
            @(posedge CLK);
            #1;
            if (n == 1) begin
                if (holdVld) DATA_IN = 3'b010;
                else begin
                    DATA_VLD = 1'b0;
                    DATA_IN  = ~v.data;
                end
            end
            checkOutput($sformatf("frame%0d_tx_cycle%0d", id, n), TX_OUT, v.bits[NB - 1 - (n - 1) / C]);
            if (BUSY) busyCnt++;
            if (DONE) begin
                doneCnt++;
                doneAt = n;
            end
            if (n == L) DATA_VLD = 1'b0;
        end
        checkOutput($sformatf("frame%0d_busy_cycles", id), busyCnt, L);
        checkOutput($sformatf("frame%0d_done_count", id), doneCnt, 1);
        checkOutput($sformatf("frame%0d_done_cycle", id), doneAt, L);
        @(posedge CLK);
        #1;
        checkOutput($sformatf("frame%0d_after_tx", id), TX_OUT, 1);
        checkOutput($sformatf("frame%0d_after_busy", id), BUSY, 0);
        checkOutput($sformatf("frame%0d_after_done", id), DONE, 0);
    endtask

    initial begin
`ifdef DIG_TX_PARITY_EN
        vecs[0] = '{3'b101, 6'b010101};
        vecs[1] = '{3'b011, 6'b011001};
        vecs[2] = '{3'b111, 6'b011111};
        vecs[3] = '{3'b000, 6'b000001};
        vecs[4] = '{3'b010, 6'b001011};
`else
        vecs[0] = '{3'b101, 6'b001011};
        vecs[1] = '{3'b011, 6'b001101};
        vecs[2] = '{3'b111, 6'b001111};
        vecs[3] = '{3'b000, 6'b000001};
        vecs[4] = '{3'b010, 6'b000101};
`endif

        // Reset state
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_tx", TX_OUT, 1);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_done", DONE, 0);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Table-driven single frames; entry 0 is repeated with DATA_VLD held during the frame
        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i, 1'b0);
        applyStimulus(vecs[0], 5, 1'b1);

        // Back-to-back frames with DATA_VLD held high
        begin
            int gap;
            int gapsChecked;
            bit seenFrame;
            gap = 0;
            gapsChecked = 0;
            seenFrame = 1'b0;
            DATA_IN  = 3'b110;
            DATA_VLD = 1'b1;
            for (int n = 0; n < 3 * (L + 1) + 3; n++) begin
                @(posedge CLK);
                #1;
                if (BUSY) begin
                    if (seenFrame && gap > 0) begin
                        checkOutput("b2b_idle_gap", gap, 1);
                        gapsChecked++;
                    end
                    gap = 0;
                    seenFrame = 1'b1;
                end else begin
                    if (seenFrame) checkOutput("b2b_idle_tx", TX_OUT, 1);
                    gap++;
                end
            end
            checkOutput("b2b_gaps_seen", int'(gapsChecked >= 3), 1);
            DATA_VLD = 1'b0;
            repeat (L + 2) @(posedge CLK);
            #1;
        end

        // Reset held low for two cycles in the middle of a frame
        begin
            int doneSeen;
            int busySeen;
            doneSeen = 0;
            busySeen = 0;
            DATA_IN  = 3'b101;
            DATA_VLD = 1'b1;
            @(posedge CLK);
            #1;
            DATA_VLD = 1'b0;
            repeat (6) @(posedge CLK);
            #1;
            RST = 1'b0;
            @(posedge CLK);
            #1;
            checkOutput("midrst_tx", TX_OUT, 1);
            checkOutput("midrst_busy", BUSY, 0);
            checkOutput("midrst_done", DONE, 0);
            @(posedge CLK);
            #1;
            RST = 1'b1;
            for (int n = 0; n < L + 4; n++) begin
                @(posedge CLK);
                #1;
                if (DONE) doneSeen++;
                if (BUSY) busySeen++;
            end
            checkOutput("midrst_no_done", doneSeen, 0);
            checkOutput("midrst_no_busy", busySeen, 0);
        end

        // Randomized traffic with occasional resets, checked by the model
        for (int n = 0; n < 600; n++) begin
            RST      = ($urandom_range(0, 79) != 0);
            DATA_VLD = ($urandom_range(0, 3) == 0);
            DATA_IN  = 3'($urandom);
            @(posedge CLK);
            #1;
        end
        RST = 1'b1;
        DATA_VLD = 1'b0;
        repeat (L + 2) @(posedge CLK);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
